// File: rtl/tdm_demux_1na8.sv
// rtl/tdm_demux_1na8.sv - TDM 1-to-CH demultiplexer: serial slots in, frame-aligned parallel word out
// Hunts for the slot-0 sync marker, then assembles CH slots per frame and flags misalignment.

module tdm_demux_1na8 #(
  parameter int CH     = 8,
  parameter int SLOT_W = 3
) (
  input  logic              iClk,
  input  logic              iRstN,
  input  logic              iEn,
  input  logic              iSync,
  input  logic              iD,
  output logic [CH-1:0]     oY,
  output logic              oValid,
  output logic [SLOT_W-1:0] oSlot,
  output logic              oErr
);

  typedef enum logic {HUNT, RECV} state_t;

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(CH - 1);
  localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);

  state_t            state, state_n;
  logic [SLOT_W-1:0] slot, slot_n;
  logic [CH-1:0]     frame_buf, frame_buf_n;
  logic [CH-1:0]     y, y_n;
  logic              valid, valid_n;
  logic              err, err_n;

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state     <= HUNT;
      slot      <= '0;
      frame_buf <= '0;
      y         <= '0;
      valid     <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      slot      <= slot_n;
      frame_buf <= frame_buf_n;
      y         <= y_n;
      valid     <= valid_n;
      err       <= err_n;
    end
  end

  always_comb begin
    state_n     = state;
    slot_n      = slot;
    frame_buf_n = frame_buf;
    y_n         = y;
    valid_n     = 1'b0;
    err_n       = 1'b0;
    if (iEn) begin
      case (state)
        HUNT: begin
          if (iSync) begin
            frame_buf_n[0] = iD;
            slot_n         = SLOT_ONE;
            state_n        = RECV;
          end else begin
            slot_n = '0;
          end
        end
        RECV: begin
          if (slot == '0) begin
            if (iSync) begin
              frame_buf_n[0] = iD;
              slot_n         = SLOT_ONE;
            end else begin
              // Expected a frame start but got none: drop lock and re-hunt.
              err_n   = 1'b1;
              state_n = HUNT;
              slot_n  = '0;
            end
          end else if (iSync) begin
            // Early sync restarts the frame; the partial one never reaches oY.
            err_n          = 1'b1;
            frame_buf_n[0] = iD;
            slot_n         = SLOT_ONE;
          end else begin
            frame_buf_n[slot] = iD;
            if (slot == LAST_SLOT) begin
              y_n     = {iD, frame_buf[CH-2:0]};
              valid_n = 1'b1;
              slot_n  = '0;
            end else begin
              slot_n = slot + SLOT_ONE;
            end
          end
        end
        default: begin
          state_n = HUNT;
          slot_n  = '0;
        end
      endcase
    end
  end

  assign oY     = y;
  assign oValid = valid;
  assign oSlot  = slot;
  assign oErr   = err;

endmodule
